aemb2_fetch: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the decode/control stage.
- Holds one PC per hardware thread, drives the Wishbone instruction bus, and registers the fetched word as ich_dat with its word address rpc_if.
- Applies branch redirects from EX (bra_ex/bpc_ex) and replays on decode forwarding hazards (hzd_fwd).
- Optionally generates the interrupt request brk_if consumed by decode.

---
 rtl/aemb2_fetch.sv | 125 ++++++++++++
 tb/tb_aemb2_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aemb2_fetch.sv
// Instruction-fetch stage: per-thread PCs, Wishbone instruction bus, branch redirect and replay.
// Optional interrupt request generation is enabled with `define AEMB2_FETCH_INT_EN.
module aemb2_fetch #(
    parameter int          AEMB_HTX = 1,
    parameter int          AEMB_IWB = 32,
    parameter logic [29:0] AEMB_RST = 30'h0
) (
    input  logic                gclk,
    input  logic                grst,
    input  logic                dena,
    input  logic                gpha,
    output logic [AEMB_IWB-1:2] iwb_adr_o,
    output logic                iwb_stb_o,
    input  logic                iwb_ack_i,
    input  logic [31:0]         iwb_dat_i,
    output logic                iena,
    output logic [31:0]         ich_dat,
    output logic [31:2]         rpc_if,
    input  logic [1:0]          bra_ex,
    input  logic [31:2]         bpc_ex,
    input  logic                hzd_fwd,
    input  logic                sys_int_i,
    input  logic                msr_ie,
    output logic [1:0]          brk_if
);

    localparam int                  PCW    = AEMB_IWB - 2;
    localparam logic [AEMB_IWB-1:2] PC_RST = AEMB_RST[PCW-1:0];
    localparam logic [AEMB_IWB-1:2] PC_ONE = {{(PCW-1){1'b0}}, 1'b1};

    logic [AEMB_IWB-1:2] pc0_q, pc0_d;
    logic [AEMB_IWB-1:2] pc1_q, pc1_d;
    logic                stb_q, stb_d;
    logic [31:0]         ich_q, ich_d;
    logic [31:2]         rpc_q, rpc_d;
    logic                adv;
    logic                cur_thr;
    logic                oth_thr;

    // In single-thread builds both selectors collapse onto PC0.
    assign cur_thr   = (AEMB_HTX != 0) && gpha;
    assign oth_thr   = (AEMB_HTX != 0) && !gpha;
    assign iwb_adr_o = cur_thr ? pc1_q : pc0_q;
    assign iwb_stb_o = stb_q;
    assign iena      = iwb_ack_i & iwb_stb_o;
    assign adv       = dena & iwb_ack_i;
    assign ich_dat   = ich_q;
    assign rpc_if    = rpc_q;

    always_comb begin
        pc0_d = pc0_q;
        pc1_d = pc1_q;
        stb_d = 1'b1;
        ich_d = ich_q;
        rpc_d = rpc_q;
        if (adv) begin
            ich_d                  = iwb_dat_i;
            rpc_d                  = '0;
            rpc_d[AEMB_IWB-1:2]    = iwb_adr_o;
            if (cur_thr) pc1_d = iwb_adr_o + PC_ONE;
            else         pc0_d = iwb_adr_o + PC_ONE;
        end
        // Later assignments win: replay beats increment, branch beats both.
        if (dena && hzd_fwd) begin
            if (oth_thr) pc1_d = rpc_q[AEMB_IWB-1:2];
            else         pc0_d = rpc_q[AEMB_IWB-1:2];
        end
        if (dena && bra_ex[1]) begin
            if (cur_thr) pc1_d = bpc_ex[AEMB_IWB-1:2];
            else         pc0_d = bpc_ex[AEMB_IWB-1:2];
        end
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            pc0_q <= PC_RST;
            pc1_q <= PC_RST;
            stb_q <= 1'b0;
            ich_q <= 32'h0;
            rpc_q <= '0;
        end else begin
            pc0_q <= pc0_d;
            pc1_q <= pc1_d;
            stb_q <= stb_d;
            ich_q <= ich_d;
            rpc_q <= rpc_d;
        end
    end

`ifdef AEMB2_FETCH_INT_EN
    logic int_s1_q, int_s1_d;
    logic int_s2_q, int_s2_d;
    logic brk_q, brk_d;
    logic unused_in;

    assign unused_in = ^{bra_ex[0], bpc_ex};

    always_comb begin
        int_s1_d = sys_int_i;
        int_s2_d = int_s1_q;
        brk_d    = int_s2_q & msr_ie;
    end

    // Interrupt path runs every cycle, independent of the pipeline enable.
    always_ff @(posedge gclk) begin
        if (grst) begin
            int_s1_q <= 1'b0;
            int_s2_q <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            int_s1_q <= int_s1_d;
            int_s2_q <= int_s2_d;
            brk_q    <= brk_d;
        end
    end

    assign brk_if = {1'b0, brk_q};
`else
    logic unused_in;

    assign unused_in = ^{bra_ex[0], bpc_ex, sys_int_i, msr_ie};
    assign brk_if    = 2'b00;
`endif

endmodule

// File: tb/tb_aemb2_fetch.sv
// Directed bench for aemb2_fetch: one single-thread and one two-thread instance.
module tb_aemb2_fetch;

    logic        clk;
    logic        rst;
    int          checks;
    int          errors;

    // single-thread instance (AEMB_HTX = 0)
    logic        s_dena, s_gpha, s_ack, s_hzd, s_int, s_msr;
    logic [31:0] s_dat;
    logic [1:0]  s_bra;
    logic [31:2] s_bpc;
    logic [31:2] s_adr;
    logic        s_stb, s_iena;
    logic [31:0] s_ich;
    logic [31:2] s_rpc;
    logic [1:0]  s_brk;

    // two-thread instance (AEMB_HTX = 1)
    logic        m_dena, m_gpha, m_ack, m_hzd, m_int, m_msr;
    logic [31:0] m_dat;
    logic [1:0]  m_bra;
    logic [31:2] m_bpc;
    logic [31:2] m_adr;
    logic        m_stb, m_iena;
    logic [31:0] m_ich;
    logic [31:2] m_rpc;
    logic [1:0]  m_brk;

    aemb2_fetch #(.AEMB_HTX(0), .AEMB_IWB(32), .AEMB_RST(30'h0)) u_s (
        .gclk(clk), .grst(rst), .dena(s_dena), .gpha(s_gpha),
        .iwb_adr_o(s_adr), .iwb_stb_o(s_stb), .iwb_ack_i(s_ack), .iwb_dat_i(s_dat),
        .iena(s_iena), .ich_dat(s_ich), .rpc_if(s_rpc), .bra_ex(s_bra), .bpc_ex(s_bpc),
        .hzd_fwd(s_hzd), .sys_int_i(s_int), .msr_ie(s_msr), .brk_if(s_brk)
    );

    aemb2_fetch #(.AEMB_HTX(1), .AEMB_IWB(32), .AEMB_RST(30'h0)) u_m (
        .gclk(clk), .grst(rst), .dena(m_dena), .gpha(m_gpha),
        .iwb_adr_o(m_adr), .iwb_stb_o(m_stb), .iwb_ack_i(m_ack), .iwb_dat_i(m_dat),
        .iena(m_iena), .ich_dat(m_ich), .rpc_if(m_rpc), .bra_ex(m_bra), .bpc_ex(m_bpc),
        .hzd_fwd(m_hzd), .sys_int_i(m_int), .msr_ie(m_msr), .brk_if(m_brk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        s_dena = 1'b0; s_gpha = 1'b0; s_ack = 1'b0; s_hzd = 1'b0; s_int = 1'b0; s_msr = 1'b0;
        s_dat  = 32'h0; s_bra = 2'b00; s_bpc = 30'h0;
        m_dena = 1'b0; m_gpha = 1'b0; m_ack = 1'b0; m_hzd = 1'b0; m_int = 1'b0; m_msr = 1'b0;
        m_dat  = 32'h0; m_bra = 2'b00; m_bpc = 30'h0;
        tick();
        tick();

        // reset state
        chk("rst_stb", s_stb, 1'b0);
        chk("rst_ich", s_ich, 32'h0);
        chk("rst_rpc", s_rpc, 30'h0);
        chk("rst_adr", s_adr, 30'h0);
        chk("rst_brk", s_brk, 2'b00);
        chk("rst_m_stb", m_stb, 1'b0);
        chk("rst_m_adr", m_adr, 30'h0);

        rst = 1'b0;
        tick();
        chk("stb_up", s_stb, 1'b1);
        chk("m_stb_up", m_stb, 1'b1);

        // sequential fetch, single thread: addresses 0..4
        s_dena = 1'b1;
        s_ack  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_dat = 32'hC0DE_0000 | k;
            settle();
            chk("seq_adr", s_adr, k);
            chk("seq_iena", s_iena, 1'b1);
            tick();
            chk("seq_rpc", s_rpc, k);
            chk("seq_ich", s_ich, 32'hC0DE_0000 | k);
        end

        // ack withheld three cycles at address 5
        s_ack = 1'b0;
        s_dat = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("wait_adr", s_adr, 30'd5);
            chk("wait_stb", s_stb, 1'b1);
            chk("wait_iena", s_iena, 1'b0);
            tick();
            chk("wait_rpc", s_rpc, 30'd4);
            chk("wait_ich", s_ich, 32'hC0DE_0004);
        end
        s_ack = 1'b1;
        s_dat = 32'hC0DE_0005;
        tick();
        chk("ack_rpc", s_rpc, 30'd5);
        chk("ack_ich", s_ich, 32'hC0DE_0005);

        // fetch 6..9 so rpc_if reaches 9
        for (int k = 6; k < 10; k++) begin
            s_dat = 32'hC0DE_0000 | k;
            tick();
        end
        chk("pre_hzd_rpc", s_rpc, 30'd9);
        chk("pre_hzd_adr", s_adr, 30'd10);

        // replay beats increment: next fetch goes back to 9
        s_hzd = 1'b1;
        s_dat = 32'h0000_AAAA;
        tick();
        s_hzd = 1'b0;
        chk("hzd_adr", s_adr, 30'd9);
        chk("hzd_rpc", s_rpc, 30'd10);
        s_dat = 32'h9999_0009;
        tick();
        chk("refetch_rpc", s_rpc, 30'd9);
        chk("refetch_ich", s_ich, 32'h9999_0009);
        chk("refetch_adr", s_adr, 30'd10);

        // branch beats replay and increment on PC0
        s_bra = 2'b10;
        s_bpc = 30'h40;
        s_hzd = 1'b1;
        s_dat = 32'h0000_BBBB;
        tick();
        s_bra = 2'b00;
        s_hzd = 1'b0;
        chk("bra_adr", s_adr, 30'h40);
        chk("bra_rpc", s_rpc, 30'd10);
        s_dat = 32'h4040_4040;
        tick();
        chk("bra_tgt_rpc", s_rpc, 30'h40);
        chk("bra_tgt_ich", s_ich, 32'h4040_4040);

        // dena low: everything holds despite ack and branch
        s_dena = 1'b0;
        s_bra  = 2'b10;
        s_bpc  = 30'h123;
        s_hzd  = 1'b1;
        s_dat  = 32'h5555_5555;
        tick();
        tick();
        chk("hold_adr", s_adr, 30'h41);
        chk("hold_rpc", s_rpc, 30'h40);
        chk("hold_ich", s_ich, 32'h4040_4040);
        s_bra = 2'b00;
        s_hzd = 1'b0;
        s_ack = 1'b0;

        // two threads: addresses 0,0,1,1,2,2
        m_dena = 1'b1;
        m_ack  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            m_gpha = k[0];
            m_dat  = 32'hF00D_0000 | k;
            settle();
            chk("mt_adr", m_adr, k / 2);
            tick();
            chk("mt_rpc", m_rpc, k / 2);
            chk("mt_ich", m_ich, 32'hF00D_0000 | k);
        end

        // thread 0 branches while decode replays thread 1 (rpc_if = 2)
        m_gpha = 1'b0;
        m_bra  = 2'b11;
        m_bpc  = 30'h40;
        m_hzd  = 1'b1;
        m_dat  = 32'h0000_CCCC;
        settle();
        chk("mt_pre_bra_adr", m_adr, 30'd3);
        tick();
        m_bra  = 2'b00;
        m_hzd  = 1'b0;
        chk("mt_bra_rpc", m_rpc, 30'd3);
        m_gpha = 1'b1;
        m_dat  = 32'h2222_2222;
        settle();
        chk("mt_replay_adr", m_adr, 30'd2);
        tick();
        chk("mt_replay_rpc", m_rpc, 30'd2);
        m_gpha = 1'b0;
        m_dat  = 32'h4040_0000;
        settle();
        chk("mt_bra_adr", m_adr, 30'h40);
        tick();
        chk("mt_bra_tgt_rpc", m_rpc, 30'h40);
        chk("mt_bra_tgt_ich", m_ich, 32'h4040_0000);
        m_gpha = 1'b1;
        settle();
        chk("mt_t1_adr", m_adr, 30'd3);
        m_dena = 1'b0;
        m_ack  = 1'b0;

        // interrupt request path
        s_msr = 1'b1;
        tick();
        chk("int_idle", s_brk, 2'b00);
        s_int = 1'b1;
        tick();
        chk("int_lat1", s_brk, 2'b00);
        tick();
        chk("int_lat2", s_brk, 2'b00);
        tick();
`ifdef AEMB2_FETCH_INT_EN
        chk("int_lat3", s_brk, 2'b01);
`else
        chk("int_lat3", s_brk, 2'b00);
`endif
        s_msr = 1'b0;
        tick();
        chk("int_mask", s_brk, 2'b00);
        s_int = 1'b0;

        // reset mid-fetch: strobe drops and a late ack is ignored
        s_dena = 1'b1;
        s_ack  = 1'b1;
        s_dat  = 32'h7777_7777;
        rst    = 1'b1;
        tick();
        chk("rst_mid_stb", s_stb, 1'b0);
        chk("rst_mid_adr", s_adr, 30'h0);
        chk("rst_mid_rpc", s_rpc, 30'h0);
        chk("rst_mid_ich", s_ich, 32'h0);
        tick();
        chk("rst_mid_adr2", s_adr, 30'h0);
        rst   = 1'b0;
        s_ack = 1'b0;
        tick();
        chk("rst_rel_stb", s_stb, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
